// File: rtl/apb_mas_ctrl.sv
// APB4 master: valid/ready command channel in, APB SETUP/ACCESS transfers out, valid/ready response back.
// Optional ACCESS-phase timeout abort is compiled in when APB_MAS_TIMEOUT_EN is defined.
module apb_mas_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLV     = 4,
    parameter int SLV_SEL_LSB = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [ADDR_WIDTH-1:0]          cmd_addr,
    input  logic [DATA_WIDTH-1:0]          cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]        cmd_strb,
    input  logic [2:0]                     cmd_prot,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic [NUM_SLV-1:0]             PSEL,
    output logic                           PENABLE,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic                           PWRITE,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [DATA_WIDTH/8-1:0]        PSTROB,
    output logic [2:0]                     PPROT,
    input  logic [NUM_SLV*DATA_WIDTH-1:0]  PRDATA,
    input  logic [NUM_SLV-1:0]             PREADY,
    input  logic [NUM_SLV-1:0]             PSLVERR
);

    localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state;
    logic [SW-1:0]           sel_idx;
    logic [SW-1:0]           dec_idx;
    logic                    dec_hit;
    logic [NUM_SLV-1:0]      dec_onehot;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    tmo_hit;

    assign dec_idx = cmd_addr[SLV_SEL_LSB +: SW];

    // Address decode for the incoming command, and slave-response mux for the latched index.
    // Index values past NUM_SLV match no slave, which is what flags a decode error.
    always_comb begin
        dec_onehot = '0;
        dec_hit    = 1'b0;
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dec_idx == SW'(i)) begin
                dec_onehot[i] = 1'b1;
                dec_hit       = 1'b1;
            end
            if (sel_idx == SW'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef APB_MAS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;

    // Abort fires on the ACCESS cycle whose wait would bring the count to TIMEOUT_CYC;
    // a PREADY on that same cycle is checked first and completes normally.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !sel_ready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYC > 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sel_idx   <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTROB    <= '0;
            PPROT     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (dec_hit) begin
                            state   <= SETUP;
                            sel_idx <= dec_idx;
                            PSEL    <= dec_onehot;
                            PADDR   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            PPROT   <= cmd_prot;
                            PWDATA  <= cmd_write ? cmd_wdata : '0;
                            PSTROB  <= cmd_write ? cmd_strb : '0;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= sel_err;
                        rsp_rdata <= (PWRITE || sel_err) ? '0 : sel_rdata;
                        state     <= RESP;
                    end else if (tmo_hit) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
